// File: rtl/morse_player.sv
// Morse code player: replays one latched 10-bit word (five 2-bit symbols,
// LSB pair first) as a lamp signal paced by an external tick enable.
// Symbol encoding: 01 = dot, 11 = dash, 00/10 = end of word.
module morse_player #(
    parameter int DOT_TICKS  = 1,
    parameter int DASH_TICKS = 3,
    parameter int GAP_TICKS  = 1,
    parameter int CNT_WIDTH  = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] code,
    output logic       light,
    output logic       busy,
    output logic       done,
    output logic [2:0] sym_idx
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MARK  = 2'd1;
    localparam logic [1:0] S_SPACE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] DOT_LEN  = CNT_WIDTH'(DOT_TICKS);
    localparam logic [CNT_WIDTH-1:0] DASH_LEN = CNT_WIDTH'(DASH_TICKS);
    localparam logic [CNT_WIDTH-1:0] GAP_LEN  = CNT_WIDTH'(GAP_TICKS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [1:0]           state, state_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx;
    logic [9:0]           shreg, shreg_nx;
    logic [2:0]           sym_nx;

    // Next-state, counter, shift-register and symbol-index computation.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        sym_nx   = sym_idx;
        case (state)
            S_IDLE: begin
                sym_nx = 3'd0;
                if (start) begin
                    shreg_nx = code;
                    // bit 0 set means a real symbol (01 or 11); bit 1 picks dash vs dot
                    if (code[0]) begin
                        state_nx = S_MARK;
                        cnt_nx   = code[1] ? DASH_LEN : DOT_LEN;
                    end else begin
                        state_nx = S_DONE;
                    end
                end
            end
            S_MARK: begin
                if (tick) begin
                    if (cnt == CNT_ONE) begin
                        // retire the current symbol; zeros fill in from the top
                        shreg_nx = {2'b00, shreg[9:2]};
                        sym_nx   = sym_idx + 3'd1;
                        if (shreg[2] && (sym_idx < 3'd4)) begin
                            state_nx = S_SPACE;
                            cnt_nx   = GAP_LEN;
                        end else begin
                            state_nx = S_DONE;
                        end
                    end else begin
                        cnt_nx = cnt - CNT_ONE;
                    end
                end
            end
            S_SPACE: begin
                if (tick) begin
                    if (cnt == CNT_ONE) begin
                        state_nx = S_MARK;
                        cnt_nx   = shreg[1] ? DASH_LEN : DOT_LEN;
                    end else begin
                        cnt_nx = cnt - CNT_ONE;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
                sym_nx   = 3'd0;
            end
            default: begin
                state_nx = S_IDLE;
                sym_nx   = 3'd0;
            end
        endcase
    end

    // State registers with asynchronous clear; reset mid-playback simply aborts.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            sym_idx <= 3'd0;
        end else begin
            // NOTE: registered state always uses non-blocking assignment.
            state   <= state_nx;
            cnt     <= cnt_nx;
            shreg   <= shreg_nx;
            sym_idx <= sym_nx;
        end
    end

    // Outputs decode straight from state, so reset clears them immediately.
    assign light = (state == S_MARK);
    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);

endmodule
